miriscv_pipe_ctrl: RTL
======================

# miriscv_pipe_ctrl

Parametrised pipeline control unit for the multi-stage miriscv core. It replaces the fixed single-stage stall/kill logic with per-stage stall and kill vectors for `NUM_STAGES` stages, and adds a configurable boot-hold counter. It also adds a registered PC-redirect path, priority between redirects from several stages, and fence draining. It sits beside the pipeline stages: it collects stall, redirect and fence requests from them and drives fetch and every stage register.

## Interface
- `NUM_STAGES`, 3: pipeline stages; index 0 = fetch, higher index = older instruction.
- `BOOT_CYCLES`, 2: cycles the boot address load is held after reset release; must be ≥1.
- `FENCE_STAGE`, 1: stage that raises `fence_req_i`; range 0..NUM_STAGES-2.
- `XLEN`, 32: PC width.
- `clk_i  in  1`: clock.
- `rst_i  in  1`: reset. Synchronous, active-high.
- `stall_req_i  in  NUM_STAGES`: stage k cannot complete this cycle (LSU, MDU and similar).
- `stage_valid_i  in  NUM_STAGES`: stage k holds a valid instruction.
- `redirect_req_i  in  NUM_STAGES`: stage k requests a PC redirect (taken branch, jal, jalr).
- `redirect_pc_i  in  NUM_STAGES×XLEN`: target PC per stage.
- `fence_req_i  in  1`: fence at `FENCE_STAGE`.
- `boot_addr_load_en_o  out  1`: fetch loads the boot address.
- `stall_o  out  NUM_STAGES`: hold stage k register.
- `kill_o  out  NUM_STAGES`: invalidate stage k register (insert bubble).
- `pc_redirect_valid_o  out  1`: fetch takes `pc_redirect_o` this cycle.
- `pc_redirect_o  out  XLEN`: registered redirect target.

## Operation
- States: BOOT, RUN, REDIRECT, FENCE.
- **BOOT:** entered on reset. A counter runs 0..BOOT_CYCLES-1. Outputs in BOOT: `boot_addr_load_en_o`=1, `stall_o`=all-1, `kill_o`=0. Leaves to RUN when the counter reaches BOOT_CYCLES-1.
- **Stall vector:** `stall_o[j]` = OR of `stall_req_i[k]` for all k ≥ j.
- **Bubble:** `kill_o[j+1]`=1 when `stall_o[j]` & ~`stall_o[j+1]`. This prevents duplicate issue.
- **Redirect select:** the highest requesting index r wins. It is accepted only if `stall_o[r]`=0.
- **Redirect accept:**
  - Same cycle: `kill_o[0..r-1]`=1.
  - The selected PC is registered into `pc_redirect_o`; next state is REDIRECT.
- **REDIRECT:**
  - Outputs: `pc_redirect_valid_o`=1, `kill_o[0]`=1.
  - Stays while `stall_o[0]`=1, holding the PC; returns to RUN otherwise.
  - A new accepted redirect in REDIRECT overwrites the PC and restarts REDIRECT.
- **Fence:** `fence_req_i` in RUN with any `stage_valid_i[k]`, k > FENCE_STAGE, enters FENCE.
  - In FENCE: `stall_o[0..FENCE_STAGE]`=1 and `kill_o[FENCE_STAGE+1]`=1.
  - Returns to RUN the cycle after all older stages are invalid.
  - A fence with older stages already empty costs 0 cycles.
- **Priority:** reset > BOOT > accepted redirect > FENCE > RUN.
  - An accepted redirect from a stage older than `FENCE_STAGE` during FENCE kills the fence and enters REDIRECT.
- **Reset mid-operation:** discards the pending redirect; every state register returns to its reset value.

## Timing
- Reset values:
  - `boot_addr_load_en_o`=1, `stall_o`=all-1, `kill_o`=0.
  - `pc_redirect_valid_o`=0, `pc_redirect_o`=0.
  - State BOOT, counter 0.
- `stall_o` and bubble `kill_o` are combinational from the inputs in the same cycle.
- Redirect latency:
  - Request at cycle t gives kill of younger stages at t.
  - `pc_redirect_valid_o` at t+1.
  - First new-path instruction is in stage 0 at t+2.
- Boot: `boot_addr_load_en_o` deasserts exactly BOOT_CYCLES cycles after the first cycle with `rst_i`=0.
- Simultaneous stall and redirect from the same stage: the redirect is deferred until the stall clears; the request must be held.

## Configuration
- `MIRISCV_PIPE_CTRL_PERF_EN` defined: adds two counters, outputs `perf_stall_cycles_o` (32b) and `perf_redirects_o` (32b).
  - Stall counter increments on each RUN cycle with `stall_o[0]`=1.
  - Redirect counter increments on each accepted redirect.
  - Both saturate at all-1 and reset to 0.
- Undefined: the ports and counters are absent.

## Structure
- `miriscv_ctrl_pkg` holds the state enum `ctrl_state_e` (BOOT, RUN, REDIRECT, FENCE) and the default constants `BOOT_CYCLES_DEFAULT` and `NUM_STAGES_DEFAULT`.
- Sub-module `miriscv_redirect_arb` (generic in NUM_STAGES, XLEN) does the oldest-first redirect selection. It outputs the winning index, a valid flag and the PC.

## Test plan
- Reset 3 cycles, release (BOOT_CYCLES=2) → `boot_addr_load_en_o`=1 for 2 cycles after release, `stall_o`=3'b111 during boot, then 3'b000.
- `stall_req_i`=3'b100 for 4 cycles → `stall_o`=3'b111 and `kill_o`=0 for 4 cycles, then 0.
- `stall_req_i`=3'b010 → `stall_o`=3'b011 and `kill_o`=3'b100.
- `redirect_req_i`=3'b110 with PCs 0x100 (stage 1) and 0x200 (stage 2):
  - Same cycle: `kill_o`=3'b011.
  - Next cycle: `pc_redirect_valid_o`=1, `pc_redirect_o`=0x200.
- `redirect_req_i[1]` with `stall_req_i[2]`=1 for 2 cycles → no kill during the stall; redirect accepted in cycle 3; `pc_redirect_valid_o` in cycle 4.
- `fence_req_i` with `stage_valid_i`=3'b111, stage 2 invalid after 2 cycles → `stall_o[1:0]`=2'b11 for 2 cycles, then RUN.
- Reset during REDIRECT → `pc_redirect_valid_o`=0 next cycle, state BOOT.

Source files
------------

// File: rtl/miriscv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// miriscv_ctrl_pkg
// Shared types and constants for the miriscv pipeline control unit.
//   ctrl_state_e        : controller FSM states (BOOT, RUN, REDIRECT, FENCE)
//   BOOT_CYCLES_DEFAULT : default length of the boot-address hold after reset
//   NUM_STAGES_DEFAULT  : default number of pipeline stages
//   width_min1()        : $clog2 that never returns 0, for index/counter widths
// ----------------------------------------------------------------------------
package miriscv_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    FENCE    = 2'd3
  } ctrl_state_e;

  localparam int BOOT_CYCLES_DEFAULT = 2;
  localparam int NUM_STAGES_DEFAULT  = 3;

  // Width needed to hold values 0..n-1, at least one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miriscv_pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// miriscv_pipe_ctrl_if
// Bundle between the pipeline stages / fetch (master) and the pipeline
// controller (slave).
//   Requests from the pipeline : stall_req_i, stage_valid_i, redirect_req_i,
//                                redirect_pc_i, fence_req_i
//   Controls to the pipeline   : boot_addr_load_en_o, stall_o, kill_o,
//                                pc_redirect_valid_o, pc_redirect_o
//   Optional (MIRISCV_PIPE_CTRL_PERF_EN): perf_stall_cycles_o, perf_redirects_o
//
// Handshake: redirect_req_i[k] with redirect_pc_i[k] is a request that is
// only taken in a cycle where stall_o[k]=0 (kill_o of the younger stages
// marks acceptance); a stage that sees its own stall_o[k]=1 must keep the
// request and PC stable. pc_redirect_valid_o/pc_redirect_o form a valid-only
// channel to fetch: fetch has no ready, it is held by stall_o[0], and the
// controller keeps the PC stable while pc_redirect_valid_o=1 and stall_o[0]=1.
// ----------------------------------------------------------------------------
interface miriscv_pipe_ctrl_if
  import miriscv_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int XLEN       = 32
);

  logic [NUM_STAGES-1:0]            stall_req_i;
  logic [NUM_STAGES-1:0]            stage_valid_i;
  logic [NUM_STAGES-1:0]            redirect_req_i;
  logic [NUM_STAGES-1:0][XLEN-1:0]  redirect_pc_i;
  logic                             fence_req_i;

  logic                             boot_addr_load_en_o;
  logic [NUM_STAGES-1:0]            stall_o;
  logic [NUM_STAGES-1:0]            kill_o;
  logic                             pc_redirect_valid_o;
  logic [XLEN-1:0]                  pc_redirect_o;

`ifdef MIRISCV_PIPE_CTRL_PERF_EN
  logic [31:0]                      perf_stall_cycles_o;
  logic [31:0]                      perf_redirects_o;

  modport master (
    output stall_req_i, stage_valid_i, redirect_req_i, redirect_pc_i, fence_req_i,
    input  boot_addr_load_en_o, stall_o, kill_o, pc_redirect_valid_o, pc_redirect_o,
    input  perf_stall_cycles_o, perf_redirects_o
  );

  modport slave (
    input  stall_req_i, stage_valid_i, redirect_req_i, redirect_pc_i, fence_req_i,
    output boot_addr_load_en_o, stall_o, kill_o, pc_redirect_valid_o, pc_redirect_o,
    output perf_stall_cycles_o, perf_redirects_o
  );
`else
  modport master (
    output stall_req_i, stage_valid_i, redirect_req_i, redirect_pc_i, fence_req_i,
    input  boot_addr_load_en_o, stall_o, kill_o, pc_redirect_valid_o, pc_redirect_o
  );

  modport slave (
    input  stall_req_i, stage_valid_i, redirect_req_i, redirect_pc_i, fence_req_i,
    output boot_addr_load_en_o, stall_o, kill_o, pc_redirect_valid_o, pc_redirect_o
  );
`endif

endinterface

// File: rtl/miriscv_redirect_arb.sv
// ----------------------------------------------------------------------------
// miriscv_redirect_arb
// Oldest-first redirect selection: among all requesting stages the highest
// index (oldest instruction) wins, because it overrides whatever the younger
// stages fetched down the wrong path.
//   i_req   : per-stage redirect request
//   i_pc    : per-stage redirect target
//   o_idx   : winning stage index (0 when no request)
//   o_valid : at least one request present
//   o_pc    : target of the winning stage (0 when no request)
// Purely combinational.
// ----------------------------------------------------------------------------
module miriscv_redirect_arb
  import miriscv_ctrl_pkg::*;
#(
  parameter  int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter  int XLEN       = 32,
  localparam int IDX_W      = width_min1(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0]           i_req,
  input  logic [NUM_STAGES-1:0][XLEN-1:0] i_pc,
  output logic [IDX_W-1:0]                o_idx,
  output logic                            o_valid,
  output logic [XLEN-1:0]                 o_pc
);

  // Ascending scan: a later (older) requester overwrites an earlier one.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    o_pc    = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (i_req[k]) begin
        o_idx   = IDX_W'(k);
        o_valid = 1'b1;
        o_pc    = i_pc[k];
      end
    end
  end

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// miriscv_pipe_ctrl
// Pipeline control unit for the multi-stage miriscv core: per-stage stall and
// kill vectors, boot-address hold after reset, registered PC redirect with
// oldest-first priority, and fence draining.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request/control bundle, see miriscv_pipe_ctrl_if
//   dbg_state_o  : current controller state
// Parameters: NUM_STAGES (0 = fetch, higher = older), BOOT_CYCLES (>=1),
// FENCE_STAGE (0..NUM_STAGES-2), XLEN.
// Optional feature macro MIRISCV_PIPE_CTRL_PERF_EN adds saturating stall and
// redirect counters (bus.perf_stall_cycles_o, bus.perf_redirects_o).
// ----------------------------------------------------------------------------
module miriscv_pipe_ctrl
  import miriscv_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = NUM_STAGES_DEFAULT,
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT,
  parameter int FENCE_STAGE = 1,
  parameter int XLEN        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  miriscv_pipe_ctrl_if.slave   bus,
  output ctrl_state_e          dbg_state_o
);

  localparam int IDX_W = width_min1(NUM_STAGES);
  localparam int CNT_W = width_min1(BOOT_CYCLES);

  ctrl_state_e           r_state;
  logic [CNT_W-1:0]      r_boot_cnt;
  logic                  r_boot_load;
  logic                  r_redirect_valid;
  logic [XLEN-1:0]       r_pc;

  logic [NUM_STAGES-1:0] w_stall_base;
  logic [NUM_STAGES-1:0] w_stall;
  logic [NUM_STAGES-1:0] w_kill;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_valid;
  logic [XLEN-1:0]       w_arb_pc;
  logic                  w_accept;
  logic                  w_older_valid;
  logic                  w_unused;

  // --------------------------------------------------------------------------
  // Stall vector: a stage cannot move while anything older is stuck.
  // --------------------------------------------------------------------------
  always_comb begin : stall_suffix_or
    logic acc;
    acc          = 1'b0;
    w_stall_base = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      acc             = acc | bus.stall_req_i[j];
      w_stall_base[j] = acc;
    end
  end

  always_comb begin
    w_stall = w_stall_base;
    if (r_state == BOOT) begin
      w_stall = '1;
    end else if (r_state == FENCE) begin
      // Hold the fence and everything younger until the older stages drain.
      for (int j = 0; j <= FENCE_STAGE; j++) begin
        w_stall[j] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Redirect arbitration and acceptance. A redirect from a stalled stage is
  // not taken; the stage keeps requesting until its stall clears.
  // --------------------------------------------------------------------------
  miriscv_redirect_arb #(
    .NUM_STAGES (NUM_STAGES),
    .XLEN       (XLEN)
  ) u_redirect_arb (
    .i_req   (bus.redirect_req_i),
    .i_pc    (bus.redirect_pc_i),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid),
    .o_pc    (w_arb_pc)
  );

  assign w_accept      = w_arb_valid && !w_stall[w_arb_idx];
  assign w_older_valid = |bus.stage_valid_i[NUM_STAGES-1:FENCE_STAGE+1];

  // Only the stages older than the fence matter for draining.
  assign w_unused = ^bus.stage_valid_i[FENCE_STAGE:0];

  // --------------------------------------------------------------------------
  // Kill vector. A stage that advances into a stalled-ahead hole would be
  // issued twice, so the first non-stalled stage past a stalled one gets a
  // bubble. Younger stages behind an accepted redirect are wrong-path.
  // --------------------------------------------------------------------------
  always_comb begin
    w_kill = '0;
    if (r_state != BOOT) begin
      for (int j = 0; j < NUM_STAGES - 1; j++) begin
        if (w_stall[j] && !w_stall[j+1]) begin
          w_kill[j+1] = 1'b1;
        end
      end
      if (r_state == FENCE) begin
        w_kill[FENCE_STAGE+1] = 1'b1;
      end
      // Stage 0 still holds the old path while fetch takes the new PC.
      if (r_state == REDIRECT) begin
        w_kill[0] = 1'b1;
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (w_accept && (IDX_W'(k) < w_arb_idx)) begin
          w_kill[k] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM with registered boot-load and redirect-valid outputs.
  // Priority: reset > BOOT > accepted redirect > FENCE > RUN.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= BOOT;
      r_boot_cnt       <= '0;
      r_boot_load      <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_pc             <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          if (r_boot_cnt == CNT_W'(BOOT_CYCLES - 1)) begin
            r_state     <= RUN;
            r_boot_cnt  <= '0;
            r_boot_load <= 1'b0;
          end else begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            // Also covers a newer redirect overwriting one still held in
            // REDIRECT, and an older-stage redirect cancelling a fence.
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
            r_pc             <= w_arb_pc;
          end else begin
            case (r_state)
              RUN: begin
                if (bus.fence_req_i && w_older_valid) begin
                  r_state <= FENCE;
                end
              end
              REDIRECT: begin
                if (!w_stall[0]) begin
                  r_state          <= RUN;
                  r_redirect_valid <= 1'b0;
                end
              end
              FENCE: begin
                if (!w_older_valid) begin
                  r_state <= RUN;
                end
              end
              default: begin
                r_state <= r_state;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.boot_addr_load_en_o = r_boot_load;
  assign bus.stall_o             = w_stall;
  assign bus.kill_o              = w_kill;
  assign bus.pc_redirect_valid_o = r_redirect_valid;
  assign bus.pc_redirect_o       = r_pc;
  assign dbg_state_o             = r_state;

`ifdef MIRISCV_PIPE_CTRL_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters.
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_stall_cycles <= '0;
      r_perf_redirects    <= '0;
    end else begin
      if ((r_state == RUN) && w_stall[0] && (r_perf_stall_cycles != '1)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
      if (w_accept && (r_perf_redirects != '1)) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cycles_o = r_perf_stall_cycles;
  assign bus.perf_redirects_o    = r_perf_redirects;
`endif

endmodule
